fetch_sequencer: RTL and testbench

Program-counter sequencer and fetch controller for the 9-bit-instruction core. Drives the 16-bit PC into the combinational instruction ROM and latches the returned 9-bit word into an instruction register. Hands the word to the decode/execute stage over a valid/ready handshake. Resolves PC-relative branches and HALT, and accepts an external flush/redirect.

---
 rtl/isa_pkg.sv | 13 +
 rtl/branch_target_calc.sv | 12 +
 rtl/fetch_sequencer.sv | 88 ++++++++
 tb/tb_fetch_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: field positions, opcodes, widths and fetch-state encoding for the 9-bit-instruction core.
package isa_pkg;
    localparam int INSTR_W    = 9;
    localparam int PC_W       = 16;
    localparam int FORMAT_BIT = 8;
    localparam int OPC_MSB    = 7;
    localparam int OPC_LSB    = 4;
    localparam int SIGN_BIT   = 3;
    localparam int OPR_MSB    = 2;
    localparam logic [3:0] BR_OPC   = 4'h2;
    localparam logic [3:0] HALT_OPC = 4'hF;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} fetch_state_e;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: next PC from a sign-magnitude relative offset, or PC+1 when not taken.
module branch_target_calc import isa_pkg::*; (
    input  logic [PC_W-1:0]  pc,
    input  logic             sign,
    input  logic [OPR_MSB:0] operand,
    input  logic             taken,
    output logic [PC_W-1:0]  next_pc
);
    logic [PC_W-1:0] mag;
    assign mag = {{(PC_W-OPR_MSB-1){1'b0}}, operand};
    assign next_pc = !taken ? pc + 16'd1 : sign ? pc - mag : pc + mag;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, instruction register and valid/ready issue with branch, HALT and flush.
module fetch_sequencer import isa_pkg::*; #(
    parameter logic [PC_W-1:0] START_PC    = 16'h0000,
    parameter logic [3:0]      BR_OPCODE   = BR_OPC,
    parameter logic [3:0]      HALT_OPCODE = HALT_OPC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc,
    output logic [PC_W-1:0]    pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               cond_flag,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] ir_out,
    output logic               halted,
    output logic               busy,
    output logic [15:0]        retired_count
);
    fetch_state_e state, state_d;
    logic [PC_W-1:0] pc_d, br_pc;
    logic [INSTR_W-1:0] ir_d;
    logic valid_d, halted_d, hs, is_br, is_halt;
    logic [15:0] cnt_d;
    assign hs      = state == ISSUE && instr_valid && instr_ready;
    assign is_br   = !ir_out[FORMAT_BIT] && ir_out[OPC_MSB:OPC_LSB] == BR_OPCODE;
    assign is_halt = !ir_out[FORMAT_BIT] && ir_out[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    assign busy    = state == FETCH || state == ISSUE;
    branch_target_calc u_btc (
        .pc      (pc_out),
        .sign    (ir_out[SIGN_BIT]),
        .operand (ir_out[OPR_MSB:0]),
        .taken   (is_br && cond_flag),
        .next_pc (br_pc)
    );
    always_comb begin
        state_d  = state;
        pc_d     = pc_out;
        ir_d     = ir_out;
        valid_d  = instr_valid;
        halted_d = halted;
        cnt_d    = retired_count;
        case (state)
            IDLE:  state_d = start ? FETCH : IDLE;
            FETCH: begin
                ir_d    = instr_in;
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (hs) begin
                valid_d  = 1'b0;
                cnt_d    = retired_count + {15'd0, retired_count != 16'hFFFF};
                state_d  = is_halt ? HALT : FETCH;
                halted_d = is_halt;
                pc_d     = is_halt ? pc_out : br_pc;
            end
            default: ;
        endcase
        // flush beats a same-cycle handshake or fetch: nothing is retired or latched
        if (flush && state != IDLE) begin
            state_d  = FETCH;
            pc_d     = flush_pc;
            ir_d     = ir_out;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            cnt_d    = retired_count;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_out        <= START_PC;
            ir_out        <= '0;
            instr_valid   <= 1'b0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= state_d;
            pc_out        <= pc_d;
            ir_out        <= ir_d;
            instr_valid   <= valid_d;
            halted        <= halted_d;
            retired_count <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a handshake scoreboard and direct state checks.
module tb_fetch_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, cond_flag = 1'b0, instr_ready = 1'b0;
    logic [15:0] flush_pc = '0, pc_out, retired_count;
    logic [8:0] instr_in, ir_out;
    logic instr_valid, halted, busy;
    logic [8:0] rom [0:65535];
    typedef struct { logic [8:0] ir; logic [15:0] pc; } exp_t;
    exp_t exp_q[$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    assign instr_in = rom[pc_out];

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .flush_pc(flush_pc),
        .pc_out(pc_out), .instr_in(instr_in), .cond_flag(cond_flag),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .ir_out(ir_out),
        .halted(halted), .busy(busy), .retired_count(retired_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] ir, input logic [15:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready && !flush) begin
                if (exp_q.size() == 0) check("unexpected_handshake", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("hs_ir", 32'(ir_out), 32'(e.ir));
                    check("hs_pc", 32'(pc_out), 32'(e.pc));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 9'h001;
        rom[5]     = 9'b000101010;
        rom[16'h10] = 9'b011110000;
        fork monitor(); join_none
        #12;
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_ir", 32'(ir_out), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(retired_count), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        check("idle_busy", 32'(busy), 32'h0);
        // streaming at full rate
        instr_ready = 1'b1;
        push(9'h001, 16'h0); push(9'h001, 16'h1); push(9'h001, 16'h2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("fetch_busy", 32'(busy), 32'h1);
        check("fetch_valid", 32'(instr_valid), 32'h0);
        tick(1);
        check("issue_valid", 32'(instr_valid), 32'h1);
        tick(5);
        check("stream_cnt", 32'(retired_count), 32'd3);
        check("stream_pc", 32'(pc_out), 32'h3);
        // backpressure
        instr_ready = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_pc", 32'(pc_out), 32'h3);
            check("stall_ir", 32'(ir_out), 32'h001);
        end
        check("stall_cnt", 32'(retired_count), 32'd3);
        push(9'h001, 16'h3);
        instr_ready = 1'b1;
        tick(1);
        check("stall_release_cnt", 32'(retired_count), 32'd4);
        check("stall_release_pc", 32'(pc_out), 32'h4);
        // taken backward branch from 5
        flush = 1'b1; flush_pc = 16'h5; cond_flag = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush5_pc", 32'(pc_out), 32'h5);
        push(9'b000101010, 16'h5);
        tick(2);
        check("br_taken_pc", 32'(pc_out), 32'h3);
        check("br_taken_cnt", 32'(retired_count), 32'd5);
        // not-taken branch from 5
        flush = 1'b1; cond_flag = 1'b0;
        tick(1);
        flush = 1'b0;
        push(9'b000101010, 16'h5);
        tick(2);
        check("br_nt_pc", 32'(pc_out), 32'h6);
        check("br_nt_cnt", 32'(retired_count), 32'd6);
        // taken branch wrapping below zero, then PC+1 wrapping past 0xFFFF
        rom[1] = 9'b000101010;
        flush = 1'b1; flush_pc = 16'h1; cond_flag = 1'b1;
        tick(1);
        flush = 1'b0;
        push(9'b000101010, 16'h1);
        tick(2);
        check("br_wrap_pc", 32'(pc_out), 32'hFFFF);
        push(9'h001, 16'hFFFF);
        tick(2);
        check("inc_wrap_pc", 32'(pc_out), 32'h0);
        check("inc_wrap_cnt", 32'(retired_count), 32'd8);
        // flush colliding with a handshake
        tick(1);
        flush = 1'b1; flush_pc = 16'h10;
        tick(1);
        flush = 1'b0;
        check("flush_hs_pc", 32'(pc_out), 32'h10);
        check("flush_hs_cnt", 32'(retired_count), 32'd8);
        check("flush_hs_valid", 32'(instr_valid), 32'h0);
        // HALT at 0x10
        push(9'b011110000, 16'h10);
        tick(2);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_cnt", 32'(retired_count), 32'd9);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("halt_pc_frozen", 32'(pc_out), 32'h10);
            check("halt_stays", 32'(halted), 32'h1);
        end
        check("halt_busy", 32'(busy), 32'h0);
        check("halt_cnt_frozen", 32'(retired_count), 32'd9);
        flush = 1'b1; flush_pc = 16'h20;
        tick(1);
        flush = 1'b0;
        check("unhalt_halted", 32'(halted), 32'h0);
        check("unhalt_pc", 32'(pc_out), 32'h20);
        check("unhalt_busy", 32'(busy), 32'h1);
        // async reset while an instruction is pending
        instr_ready = 1'b0;
        tick(1);
        check("pre_rst_valid", 32'(instr_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_pc", 32'(pc_out), 32'h0);
        check("arst_valid", 32'(instr_valid), 32'h0);
        check("arst_ir", 32'(ir_out), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_cnt", 32'(retired_count), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);
        check("post_rst_idle_busy", 32'(busy), 32'h0);
        check("post_rst_idle_pc", 32'(pc_out), 32'h0);
        instr_ready = 1'b1;
        push(9'h001, 16'h0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        check("restart_cnt", 32'(retired_count), 32'd1);
        check("restart_pc", 32'(pc_out), 32'h1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
